// File: rtl/kgp_risc_pkg.sv
// Purpose: shared KGP-RISC opcode constants, default widths and writeback select encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package kgp_risc_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 5;

    localparam logic [5:0] OP_ALU_R = 6'b000000;
    localparam logic [5:0] OP_ALU_I = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b000011;
    localparam logic [5:0] OP_BR    = 6'b000100;
    localparam logic [5:0] OP_BL    = 6'b000101;

    // Which value feeds the register-file write data
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2,
        SRC_RA   = 2'd3
    } wbSrc_t;

    // Which value feeds the register-file write address
    typedef enum logic [1:0] {
        ADDR_ZERO = 2'd0,
        ADDR_RS   = 2'd1,
        ADDR_LINK = 2'd2
    } wbAddrSel_t;

endpackage

// File: rtl/wb_decode.sv
// Purpose: pure combinational writeback decode of opcode into write enable and source/address selects.
// Latency: combinational, zero cycles.
// Backpressure: none; decodes every cycle.
module wb_decode
    import kgp_risc_pkg::*;
(
    input  logic [5:0]  opcode,
    output logic        regWrite,
    output wbSrc_t      srcSel,
    output wbAddrSel_t  addrSel
);

    // Map each opcode to its writeback behaviour; unknown opcodes never write
    always_comb begin
        regWrite = 1'b0;
        srcSel   = SRC_ZERO;
        addrSel  = ADDR_ZERO;
        unique case (opcode)
            OP_ALU_R, OP_ALU_I: begin
                regWrite = 1'b1;
                srcSel   = SRC_ALU;
                addrSel  = ADDR_RS;
            end
            OP_LW: begin
                regWrite = 1'b1;
                srcSel   = SRC_MEM;
                addrSel  = ADDR_RS;
            end
            OP_BL: begin
                regWrite = 1'b1;
                srcSel   = SRC_RA;
                addrSel  = ADDR_LINK;
            end
            default: begin
                regWrite = 1'b0;
                srcSel   = SRC_ZERO;
                addrSel  = ADDR_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/write_address.sv
// Purpose: writeback stage; selects register-file write address/data/enable from the decoded opcode.
// Latency: one clk cycle, inputs at edge N appear on outputs after edge N.
// Backpressure: none; a new instruction is accepted every cycle.
module write_address
    import kgp_risc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] rsAddr,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] MemOut,
    output logic [ADDR_W-1:0] wrAddr,
    output logic              RegWrite,
    output logic [DATA_W-1:0] wrData
);

    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic              decWrite;
    wbSrc_t            decSrc;
    wbAddrSel_t        decAddr;
    logic [ADDR_W-1:0] nextAddr;
    logic [DATA_W-1:0] nextData;

    wb_decode uDecode (
        .opcode   (opcode),
        .regWrite (decWrite),
        .srcSel   (decSrc),
        .addrSel  (decAddr)
    );

    // Select write data; non-writing opcodes drive zero so idle outputs stay clean
    always_comb begin
        nextData = '0;
        unique case (decSrc)
            SRC_ALU:  nextData = ALUOut;
            SRC_MEM:  nextData = MemOut;
            SRC_RA:   nextData = ra;
            default:  nextData = '0;
        endcase
    end

    // Select write address; branch-and-link ignores rsAddr and targets the link register
    always_comb begin
        nextAddr = '0;
        unique case (decAddr)
            ADDR_RS:   nextAddr = rsAddr;
            ADDR_LINK: nextAddr = LINK_ADDR;
            default:   nextAddr = '0;
        endcase
    end

    // Register outputs; reset discards whatever instruction is sampled on that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            wrAddr   <= '0;
            wrData   <= '0;
            RegWrite <= 1'b0;
        end else begin
            wrAddr   <= nextAddr;
            wrData   <= nextData;
            RegWrite <= decWrite;
        end
    end

endmodule

// File: tb/tb_write_address.sv
// Purpose: directed, table-driven self-checking bench for write_address.
// Latency: expects registered outputs one clk after the inputs are sampled.
// Backpressure: n/a.
module tb_write_address;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [5:0]    opcode;
    logic [AW-1:0] rsAddr;
    logic [DW-1:0] ALUOut;
    logic [DW-1:0] ra;
    logic [DW-1:0] MemOut;
    logic [AW-1:0] wrAddr;
    logic          RegWrite;
    logic [DW-1:0] wrData;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]    op;
        logic [AW-1:0] rs;
        logic [DW-1:0] alu;
        logic [DW-1:0] raV;
        logic [DW-1:0] mem;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expData;
        logic          expWe;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    write_address #(.DATA_W(DW), .ADDR_W(AW), .LINK_REG(31)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .rsAddr   (rsAddr),
        .ALUOut   (ALUOut),
        .ra       (ra),
        .MemOut   (MemOut),
        .wrAddr   (wrAddr),
        .RegWrite (RegWrite),
        .wrData   (wrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [5:0] op, input logic [AW-1:0] rs,
                                   input logic [DW-1:0] alu, input logic [DW-1:0] raV,
                                   input logic [DW-1:0] mem, input logic [AW-1:0] eA,
                                   input logic [DW-1:0] eD, input logic eW);
        vec_t v;
        v.op = op; v.rs = rs; v.alu = alu; v.raV = raV; v.mem = mem;
        v.expAddr = eA; v.expData = eD; v.expWe = eW;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [5:0] op, input logic [AW-1:0] rs,
                         input logic [DW-1:0] alu, input logic [DW-1:0] raV,
                         input logic [DW-1:0] mem);
        rst = r; opcode = op; rsAddr = rs; ALUOut = alu; ra = raV; MemOut = mem;
    endtask

    task automatic check(input string name, input logic [AW-1:0] eA,
                         input logic [DW-1:0] eD, input logic eW);
        checks++;
        if (wrAddr !== eA || wrData !== eD || RegWrite !== eW) begin
            failures++;
            $display("FAIL %s: got wrAddr=%0d wrData=0x%08h RegWrite=%0b, want wrAddr=%0d wrData=0x%08h RegWrite=%0b",
                     name, wrAddr, wrData, RegWrite, eA, eD, eW);
        end
    endtask

    // Apply inputs just after an edge, sample outputs 1 time unit after the next edge
    task automatic stepCheck(input string name, input logic [AW-1:0] eA,
                             input logic [DW-1:0] eD, input logic eW);
        @(posedge clk);
        #1;
        check(name, eA, eD, eW);
    endtask

    initial begin
        vecs[0]  = mkVec(6'b000000, 5'd7,  32'd70,         32'd100,        32'd100,        5'd7,  32'd70,         1'b1);
        vecs[1]  = mkVec(6'b000010, 5'd3,  32'd70,         32'd100,        32'hDEADBEEF,   5'd3,  32'hDEADBEEF,   1'b1);
        vecs[2]  = mkVec(6'b000101, 5'd7,  32'd5,          32'd100,        32'd6,          5'd31, 32'd100,        1'b1);
        vecs[3]  = mkVec(6'b000011, 5'd9,  32'd5,          32'd100,        32'd6,          5'd0,  32'd0,          1'b0);
        vecs[4]  = mkVec(6'b111111, 5'd9,  32'd5,          32'd100,        32'd6,          5'd0,  32'd0,          1'b0);
        vecs[5]  = mkVec(6'b000001, 5'd12, 32'hFFFFFFFF,   32'd1,          32'd2,          5'd12, 32'hFFFFFFFF,   1'b1);
        vecs[6]  = mkVec(6'b000100, 5'd4,  32'd1,          32'd2,          32'd3,          5'd0,  32'd0,          1'b0);
        vecs[7]  = mkVec(6'b000000, 5'd0,  32'h80000001,   32'd9,          32'd8,          5'd0,  32'h80000001,   1'b1);
        vecs[8]  = mkVec(6'b000110, 5'd5,  32'd77,         32'd78,         32'd79,         5'd0,  32'd0,          1'b0);
        vecs[9]  = mkVec(6'b100000, 5'd6,  32'd88,         32'd89,         32'd90,         5'd0,  32'd0,          1'b0);
        vecs[10] = mkVec(6'b000010, 5'd31, 32'd123,        32'd124,        32'd0,          5'd31, 32'd0,          1'b1);
        vecs[11] = mkVec(6'b000101, 5'd0,  32'd1,          32'hFFFFFFFE,   32'd3,          5'd31, 32'hFFFFFFFE,   1'b1);
        vecs[12] = mkVec(6'b100101, 5'd8,  32'd44,         32'd45,         32'd46,         5'd0,  32'd0,          1'b0);
        vecs[13] = mkVec(6'b000001, 5'd30, 32'h7FFF0000,   32'h12345678,   32'h9ABCDEF0,   5'd30, 32'h7FFF0000,   1'b1);

        // Reset with a writing instruction present must still clear outputs
        drive(1'b1, 6'b000000, 5'd7, 32'd70, 32'd100, 32'd100);
        stepCheck("reset_clear", 5'd0, 32'd0, 1'b0);
        drive(1'b1, 6'b000101, 5'd3, 32'd1, 32'd2, 32'd3);
        stepCheck("reset_held", 5'd0, 32'd0, 1'b0);

        // Table-driven single-instruction vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b0, vecs[i].op, vecs[i].rs, vecs[i].alu, vecs[i].raV, vecs[i].mem);
            stepCheck($sformatf("vec%0d_op%06b", i, vecs[i].op),
                      vecs[i].expAddr, vecs[i].expData, vecs[i].expWe);
        end

        // Outputs are registered: changing inputs between edges must not move them
        drive(1'b0, 6'b000000, 5'd10, 32'd1000, 32'd0, 32'd0);
        stepCheck("latency_first", 5'd10, 32'd1000, 1'b1);
        drive(1'b0, 6'b000010, 5'd11, 32'd0, 32'd0, 32'd2000);
        #3;
        check("latency_hold", 5'd10, 32'd1000, 1'b1);
        stepCheck("latency_next", 5'd11, 32'd2000, 1'b1);

        // Back-to-back writes then mid-stream reset discarding the sampled instruction
        drive(1'b0, 6'b000000, 5'd1, 32'd11, 32'd0, 32'd0);
        stepCheck("b2b_alu", 5'd1, 32'd11, 1'b1);
        drive(1'b0, 6'b000010, 5'd2, 32'd0, 32'd0, 32'd22);
        stepCheck("b2b_lw", 5'd2, 32'd22, 1'b1);
        drive(1'b1, 6'b000000, 5'd3, 32'd33, 32'd0, 32'd0);
        stepCheck("b2b_rst", 5'd0, 32'd0, 1'b0);
        drive(1'b0, 6'b000010, 5'd4, 32'd0, 32'd0, 32'd44);
        stepCheck("post_rst_first", 5'd4, 32'd44, 1'b1);

        // Write to a writing opcode then an idle one: outputs return to zero
        drive(1'b0, 6'b000011, 5'd9, 32'd5, 32'd6, 32'd7);
        stepCheck("sw_after_lw", 5'd0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
